// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, opcode legality.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB    = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL    = 3'b010;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'b011;
  localparam logic [OP_W-1:0] OP_PASS_B = 3'b100;
  localparam logic [OP_W-1:0] OP_NOP    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Opcodes above pass-B are rejected without touching the ALU.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_PASS_B);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the one
// that was not granted last.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // Purely combinational grant selection from the current valids.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = valid0 | valid1;
    grant       = 1'b0;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: round-robin accept,
// one-cycle issue, wait out the ALU latency, return the result to the owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OP_W  = alu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_z,
  output logic             resp_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,

  output logic             busy
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] data_q;
  logic             z_q, err_q;

  logic             grant_valid, grant;
  logic             accept, resp_fire;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign accept    = (state_q == ST_IDLE) && grant_valid;
  assign resp_fire = (state_q == ST_RESP) && (owner_q ? resp1_ready : resp0_ready);
  assign sel_op    = grant ? req1_op : req0_op;
  assign sel_a     = grant ? req1_a  : req0_a;
  assign sel_b     = grant ? req1_b  : req0_b;

  // State register with synchronous reset; a reset drops any in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: illegal opcodes skip the ALU and go straight to RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = is_legal_op(sel_op) ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  if (resp_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operation latch, result capture and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= OP_NOP;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      z_q          <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        a_q     <= sel_a;
        b_q     <= sel_b;
        owner_q <= grant;
        data_q  <= '0;
        z_q     <= 1'b0;
        err_q   <= ~is_legal_op(sel_op);
      end
      if (state_q == ST_WAIT) begin
        data_q <= alu_out;
        z_q    <= alu_z;
        err_q  <= 1'b0;
      end
      if (resp_fire) begin
        last_grant_q <= owner_q;
      end
    end
  end

  // Handshake and ALU drive decoded from the current state.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = OP_NOP;
    busy        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        req0_ready = grant_valid && !grant;
        req1_ready = grant_valid &&  grant;
      end
      ST_ISSUE: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_sel = op_q;
      end
      ST_RESP: begin
        resp0_valid = !owner_q;
        resp1_valid =  owner_q;
      end
      default: ;
    endcase
  end

  assign resp_data = data_q;
  assign resp_z    = z_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and
// a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [15:0] resp_data;
  logic        resp_z, resp_err;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_out = '0;
  logic        alu_z = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Bench-side view of what each requester is presenting.
  logic [1:0]  pend_v = 2'b00;
  logic [2:0]  pend_op [2];
  logic [15:0] pend_a  [2];
  logic [15:0] pend_b  [2];
  int          last_owner = 1;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_z(resp_z), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_z(alu_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered ALU sitting beside the arbiter; select 111 holds the output.
  always @(posedge clk) begin
    case (alu_sel)
      3'b000: begin alu_out <= 16'(alu_b + alu_a); alu_z <= (16'(alu_b + alu_a) == 16'h0); end
      3'b001: begin alu_out <= 16'(alu_b - alu_a); alu_z <= (16'(alu_b - alu_a) == 16'h0); end
      3'b010: begin alu_out <= 16'(alu_b * alu_a); alu_z <= 1'b0; end
      3'b011: begin alu_out <= alu_a; alu_z <= 1'b0; end
      3'b100: begin alu_out <= alu_b; alu_z <= 1'b0; end
      default: ;
    endcase
  end

  // Requesters may not withdraw an operation before it is accepted.
  logic prev_wait0 = 1'b0, prev_wait1 = 1'b0;
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_wait0) assert (req0_valid) else $error("protocol violation: req0_valid dropped before ready");
      if (prev_wait1) assert (req1_valid) else $error("protocol violation: req1_valid dropped before ready");
    end
    prev_wait0 <= (rst_n === 1'b1) && req0_valid && !req0_ready;
    prev_wait1 <= (rst_n === 1'b1) && req1_valid && !req1_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected response straight from the opcode table.
  function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic z, output logic e);
    int unsigned prod;
    d = 16'h0; z = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin d = 16'((int'(b) + int'(a)) % 65536); z = (d == 0); end
      3'd1: begin d = 16'((int'(b) - int'(a) + 65536) % 65536); z = (d == 0); end
      3'd2: begin prod = int'(b) * int'(a); d = 16'(prod % 65536); end
      3'd3: d = a;
      3'd4: d = b;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic raise(input int n, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    pend_v[n] = 1'b1; pend_op[n] = op; pend_a[n] = a; pend_b[n] = b;
    if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic drop(input int n);
    pend_v[n] = 1'b0;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, 0);
    check({tag, "_req_ready"}, {req1_ready, req0_ready}, 0);
    check({tag, "_resp_data"}, {resp_err, resp_z, resp_data}, 0);
    check({tag, "_alu"}, {alu_sel, alu_a, alu_b}, {3'b111, 32'h0});
  endtask

  // One transaction: the bench predicts the winner, follows it through the
  // latency, holds the response for 'hold' cycles and then consumes it.
  task automatic txn(input int hold);
    int          who;
    logic [2:0]  op;
    logic [15:0] a, b, ed;
    logic        ez, ee;
    who = (pend_v == 2'b11) ? 1 - last_owner : (pend_v[0] ? 0 : 1);
    op = pend_op[who]; a = pend_a[who]; b = pend_b[who];
    ref_model(op, a, b, ed, ez, ee);
    #1;
    check("grant", {req1_ready, req0_ready}, (who == 0) ? 2'b01 : 2'b10);
    check("idle_busy", busy, 0);
    tick();
    drop(who);
    if (!ee) begin
      check("issue_alu", {alu_sel, alu_a, alu_b}, {op, a, b});
      check("issue_resp_valid", {resp1_valid, resp0_valid}, 0);
      check("issue_busy", busy, 1);
      tick();
      check("wait_alu", {alu_sel, alu_a, alu_b}, {3'b111, 32'h0});
      check("wait_resp_valid", {resp1_valid, resp0_valid}, 0);
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", {resp1_valid, resp0_valid}, (who == 0) ? 2'b01 : 2'b10);
      check("resp_payload", {resp_err, resp_z, resp_data}, {ee, ez, ed});
      check("resp_alu", {alu_sel, alu_a, alu_b}, {3'b111, 32'h0});
      check("resp_req_ready", {req1_ready, req0_ready}, 0);
      if (h < hold) tick();
    end
    if (who == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    check("done_idle", {busy, resp1_valid, resp0_valid}, 0);
    last_owner = who;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    pend_op[0] = 0; pend_op[1] = 0; pend_a[0] = 0; pend_a[1] = 0; pend_b[0] = 0; pend_b[1] = 0;
    tick(); tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Lone requesters: add, sub to zero, wrapping multiply.
    raise(0, 3'b000, 16'd3, 16'd5);       txn(0);
    raise(1, 3'b001, 16'd7, 16'd7);       txn(0);
    raise(1, 3'b010, 16'h0100, 16'h0100); txn(0);

    // Rejected opcode answers one cycle after accept, ALU untouched.
    raise(0, 3'b110, 16'h1234, 16'h5678); txn(0);

    // req0 wins a tie, holds its response for 5 cycles; req1 follows immediately.
    raise(1, 3'b011, 16'hbeef, 16'h0001); txn(0);
    raise(0, 3'b100, 16'h0001, 16'hcafe);
    raise(1, 3'b000, 16'hffff, 16'h0001);
    txn(5);
    txn(0);

    // Reset while the ALU result is in flight.
    raise(0, 3'b000, 16'd1, 16'd2);
    #1;
    check("rst_accept", {req1_ready, req0_ready}, 2'b01);
    tick();
    drop(0);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_values("mid_reset");
    rst_n = 1'b1;
    last_owner = 1;
    tick();
    check("post_reset_no_resp", {resp1_valid, resp0_valid}, 0);

    // Both requesters valid every cycle: grants alternate starting with 0.
    raise(0, 3'b000, 16'd10, 16'd20);
    raise(1, 3'b001, 16'd1, 16'd21);
    for (int i = 0; i < 4; i++) begin
      txn(0);
      if (!pend_v[0]) raise(0, 3'(i), 16'(i + 4), 16'(i * 3));
      if (!pend_v[1]) raise(1, 3'(4 - i), 16'(i + 9), 16'(i + 1));
    end
    txn(0);
    txn(0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend_v[n] && ($urandom_range(0, 1) == 1 || pend_v == 2'b00))
          raise(n, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      end
      txn($urandom_range(0, 3));
    end
    while (pend_v != 2'b00) txn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two requesters (e.g. the instruction datapath and a DMA/address-generation unit). Arbitrates round-robin, issues one operation at a time with valid/ready handshakes, and waits out the ALU's one-cycle registered latency. Captures the result and zero flag, then returns them to the requester that issued the operation. Sits between the requesters and the ALU, and is the only driver of the ALU's A, B and select inputs.

## Interface
- WIDTH, 16, operand/result width; must equal the ALU data width
- OP_W, 3, opcode width; must equal the ALU select width
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- reqN_valid  in  1  (N=0,1) requester N presents an operation
- reqN_ready  out  1  operation accepted this cycle when high with reqN_valid
- reqN_op  in  OP_W  opcode: 000 add B+A, 001 sub B−A, 010 mul B*A, 011 pass A, 100 pass B
- reqN_a, reqN_b  in  WIDTH  operands
- respN_valid  out  1  result for requester N is available
- respN_ready  in  1  requester N consumes the response
- resp_data  out  WIDTH  result, shared by both response channels
- resp_z  out  1  ALU zero flag captured with the result
- resp_err  out  1  illegal opcode was rejected
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_sel  out  OP_W  to ALU select
- alu_out  in  WIDTH  ALU result (registered inside the ALU)
- alu_z  in  1  ALU zero flag
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Grant is combinational from the valid inputs. Only one valid: that requester wins. Both valid: the requester not granted last wins.
  - reqN_ready = (state==IDLE) && grant==N.
  - On accept, latch op, a, b and the owner id. Go to ISSUE, or to RESP with err=1 if op ≥ 101.
- ISSUE: drive alu_a/alu_b/alu_sel from the latched values for exactly one cycle. Go to WAIT.
- WAIT: capture alu_out into resp_data and alu_z into resp_z, with err=0. Go to RESP.
- RESP
  - respN_valid is high only for the owner.
  - On respN_ready, update last_grant to the owner and go to IDLE.
  - resp_data, resp_z and resp_err stay stable while valid.
- Rejected opcode: resp_data=0, resp_z=0, resp_err=1, and the ALU is never issued.
- In every state other than ISSUE, alu_sel=111 (NOP). The ALU has no action for 111 and holds its output. alu_a/alu_b=0.
- Flag rules: resp_z reflects the ALU result only for add/sub; the ALU forces it to 0 for mul/pass. Results are WIDTH bits with wrap-around; the mul upper half is discarded.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is a protocol violation, flagged by a bench assertion.

## Timing
- Accept at cycle T → ISSUE at T+1 → WAIT at T+2 (alu_out valid) → respN_valid at T+3.
- Fastest back-to-back throughput: one operation per 4 cycles (RESP with ready held high, then IDLE).
- Illegal opcode: accept at T → respN_valid at T+1.
- No new request is accepted until the current response has been consumed.
- Reset (rst_n=0 at a clock edge, in any state):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - All ready/valid outputs 0; resp_data/resp_z/resp_err=0; alu_sel=111; alu_a/alu_b=0; busy=0.
  - An in-flight operation is dropped without a response.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_PASS_A=011, OP_PASS_B=100, OP_NOP=111
  - the FSM state encoding
  - an is_legal_op function (op ≤ 100)
- Sub-module rr_arb2: two-input round-robin grant logic, combinational, with last_grant as an input.
- The ALU is instantiated at the level above, not inside this block.

## Test plan
- Only req0 valid, op=000, a=3, b=5 → req0_ready at T; alu_sel=000 at T+1; resp0_valid at T+3 with data=8, z=0, err=0.
- req1 op=001, a=7, b=7 → resp1 data=0, z=1. Then req1 op=010, a=0x0100, b=0x0100 → data=0x0000, z=0 (mul wraps, flag forced 0).
- Both valid every cycle after reset → grants alternate 0,1,0,1. Each response appears only on the owner's channel.
- Illegal: req0 op=110 → resp0_valid at T+1, err=1, data=0, and alu_sel stays 111 throughout.
- Hold resp0_ready=0 for 5 cycles → data/z/err stable, req1_ready stays 0. Release ready → IDLE, req1 granted next cycle.
- Assert rst_n=0 during WAIT → next cycle state=IDLE, all outputs at reset values, no response delivered. First request after reset goes to req0 when both are valid.
